// File: rtl/igbt_status_uart_tx.sv
// IGBT/SCR status reporter: sends a 5-byte 8N1 frame (A5, STAT, CNT_H, CNT_L, CHK)
// on request or, optionally, whenever the switch on-state flags change.
module igbt_status_uart_tx #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned AUTO_REPORT = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [4:0]  igbt_status,
    input  logic [1:0]  scr_status,
    input  logic [15:0] pulse_cnt,
    input  logic        report_req,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic        frame_done
);

    localparam int unsigned BAUD_DIV  = CLK_FREQ / BAUD_RATE;
    localparam int unsigned BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [2:0]  LAST_BYTE = 3'd4;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state, state_d;
    logic [BW-1:0] baud_cnt, baud_d;
    logic [2:0]    bit_idx, bit_d;
    logic [2:0]    byte_idx, byte_d;
    logic [7:0]    shift, shift_d;
    logic [7:0]    stat_q, stat_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [6:0]    prev_q;
    logic          pend_q, pend_d;
    logic          txd_d, busy_d, done_d;

    logic [6:0]    status_now;
    logic          changed;
    logic          trig;
    logic          baud_end;
    logic [7:0]    cur_byte;

    assign status_now = {scr_status, igbt_status};
    assign changed    = (AUTO_REPORT != 0) && (status_now != prev_q);
    assign trig       = report_req | changed;
    assign baud_end   = (baud_cnt == BAUD_LAST);

    // Byte currently on the wire, built from the values frozen at frame start
    always_comb begin
        cur_byte = SYNC_BYTE;
        case (byte_idx)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = stat_q;
            3'd2:    cur_byte = cnt_q[15:8];
            3'd3:    cur_byte = cnt_q[7:0];
            default: cur_byte = stat_q ^ cnt_q[15:8] ^ cnt_q[7:0];
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_idx;
        byte_d  = byte_idx;
        shift_d = shift;
        stat_d  = stat_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        txd_d   = uart_txd;
        busy_d  = tx_busy;
        done_d  = 1'b0;

        case (state)
            IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                // A merged pending trigger waits out the frame_done cycle first
                if (trig || (pend_q && !frame_done)) begin
                    state_d = START;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                    stat_d  = {1'b0, scr_status, igbt_status};
                    cnt_d   = pulse_cnt;
                    byte_d  = '0;
                    bit_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    txd_d   = cur_byte[0];
                    shift_d = {1'b0, cur_byte[7:1]};
                end else begin
                    baud_d = baud_cnt + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        txd_d   = shift[0];
                        shift_d = {1'b0, shift[7:1]};
                        bit_d   = bit_idx + 3'd1;
                    end
                end else begin
                    baud_d = baud_cnt + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_idx == LAST_BYTE) begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = START;
                        txd_d   = 1'b0;
                        byte_d  = byte_idx + 3'd1;
                    end
                end else begin
                    baud_d = baud_cnt + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state != IDLE) && trig) begin
            pend_d = 1'b1;
        end
    end

    // State and output registers; previous-status tracks inputs through reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            shift      <= '0;
            stat_q     <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            prev_q     <= status_now;
            uart_txd   <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            baud_cnt   <= baud_d;
            bit_idx    <= bit_d;
            byte_idx   <= byte_d;
            shift      <= shift_d;
            stat_q     <= stat_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            prev_q     <= status_now;
            uart_txd   <= txd_d;
            tx_busy    <= busy_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_igbt_status_uart_tx.sv
// Directed bench: a default-rate instance for the full-length frame and a
// fast instance (10 cycles/bit) for trigger, merge, capture and reset cases.
module tb_igbt_status_uart_tx;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [4:0]  igbt_status;
    logic [1:0]  scr_status;
    logic [15:0] pulse_cnt;
    logic        report_req;
    logic        txd0, busy0, done0;
    logic        txd1, busy1, done1;

    igbt_status_uart_tx dut0 (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .igbt_status (igbt_status),
        .scr_status  (scr_status),
        .pulse_cnt   (pulse_cnt),
        .report_req  (report_req),
        .uart_txd    (txd0),
        .tx_busy     (busy0),
        .frame_done  (done0)
    );

    igbt_status_uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .AUTO_REPORT(1)) dut1 (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .igbt_status (igbt_status),
        .scr_status  (scr_status),
        .pulse_cnt   (pulse_cnt),
        .report_req  (report_req),
        .uart_txd    (txd1),
        .tx_busy     (busy1),
        .frame_done  (done1)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int div = 434;
    logic sel = 1'b0;
    logic txd_m, busy_m, done_m;

    assign txd_m  = sel ? txd1  : txd0;
    assign busy_m = sel ? busy1 : busy0;
    assign done_m = sel ? done1 : done0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [39:0] bytes;
        bit          framing;
        int          len;
        int          start_cyc;
        int          end_cyc;
        logic        done_end;
    } frame_t;

    frame_t fq[$];

    // Line receiver: samples each bit at its mid-point, frame ends when tx_busy drops
    bit   mon_act = 1'b0;
    int   mc = 0;
    int   m_start = 0;
    logic bits [50];
    always @(negedge sys_clk) begin : mon
        frame_t     f;
        logic [7:0] bt;
        if (done_m === 1'b1) done_cnt++;
        if (!mon_act && txd_m === 1'b0 && busy_m === 1'b1) begin
            mon_act = 1'b1;
            mc      = 0;
            m_start = cyc;
            for (int i = 0; i < 50; i++) bits[i] = 1'bx;
        end
        if (mon_act) begin
            if (busy_m !== 1'b1 || mc >= 60 * div) begin
                f.len       = mc;
                f.start_cyc = m_start;
                f.end_cyc   = cyc;
                f.done_end  = done_m;
                f.framing   = 1'b1;
                f.bytes     = '0;
                for (int k = 0; k < 5; k++) begin
                    if (bits[10*k] !== 1'b0 || bits[10*k+9] !== 1'b1) f.framing = 1'b0;
                    for (int j = 0; j < 8; j++) bt[j] = bits[10*k+1+j];
                    f.bytes = {f.bytes[31:0], bt};
                end
                fq.push_back(f);
                mon_act = 1'b0;
            end else begin
                if ((mc % div) == (div / 2) && (mc / div) < 50) bits[mc / div] = txd_m;
                mc++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t;
        t = 0;
        while (fq.size() < n && t < budget) begin
            @(negedge sys_clk);
            t++;
        end
        check("frame_arrival", 64'(fq.size() >= n), 64'(1));
    endtask

    task automatic pop(output frame_t f);
        f = '{bytes: '0, framing: 1'b0, len: 0, start_cyc: 0, end_cyc: 0, done_end: 1'b0};
        if (fq.size() > 0) f = fq.pop_front();
    endtask

    task automatic pulse_req(output int at);
        at = cyc;
        report_req = 1'b1;
        @(negedge sys_clk);
        report_req = 1'b0;
    endtask

    initial begin
        frame_t f, f2;
        int rc, d0;

        sys_rst_n   = 1'b0;
        igbt_status = 5'b00001;
        scr_status  = 2'b10;
        pulse_cnt   = 16'h1234;
        report_req  = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_txd0",  64'(txd0),  64'(1));
        check("rst_busy0", 64'(busy0), 64'(0));
        check("rst_done0", 64'(done0), 64'(0));
        check("rst_txd1",  64'(txd1),  64'(1));
        check("rst_busy1", 64'(busy1), 64'(0));
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("no_spurious_after_reset", 64'(busy0 | busy1), 64'(0));

        // Full-rate frame
        d0 = done_cnt;
        pulse_req(rc);
        wait_frames(1, 23000);
        pop(f);
        check("f1_bytes",   64'(f.bytes),         64'(40'hA5_41_12_34_67));
        check("f1_framing", 64'(f.framing),       64'(1));
        check("f1_len",     64'(f.len),           64'(21700));
        check("f1_latency", 64'(f.start_cyc - rc), 64'(1));
        check("f1_done",    64'(f.done_end),      64'(1));
        repeat (3) @(negedge sys_clk);
        check("f1_done_once", 64'(done_cnt - d0), 64'(1));

        // Auto-report on status change (fast instance)
        sel = 1'b1;
        div = 10;
        igbt_status = 5'b00000;
        scr_status  = 2'b00;
        repeat (700) @(negedge sys_clk);
        fq.delete();
        pulse_cnt = 16'hBEEF;
        rc = cyc;
        igbt_status = 5'b00100;
        wait_frames(1, 700);
        pop(f);
        check("auto_bytes",   64'(f.bytes),          64'(40'hA5_04_BE_EF_55));
        check("auto_framing", 64'(f.framing),        64'(1));
        check("auto_latency", 64'(f.start_cyc - rc), 64'(1));
        check("auto_len",     64'(f.len),            64'(500));

        // Three requests during a frame merge into one follow-up frame
        repeat (5) @(negedge sys_clk);
        fq.delete();
        d0 = done_cnt;
        pulse_cnt = 16'h0102;
        pulse_req(rc);
        repeat (100) @(negedge sys_clk);
        pulse_req(rc);
        repeat (100) @(negedge sys_clk);
        pulse_req(rc);
        repeat (100) @(negedge sys_clk);
        pulse_req(rc);
        pulse_cnt = 16'h0A0B;
        wait_frames(2, 1500);
        pop(f);
        pop(f2);
        check("merge_f1_bytes", 64'(f.bytes),  64'(40'hA5_04_01_02_07));
        check("merge_f2_bytes", 64'(f2.bytes), 64'(40'hA5_04_0A_0B_05));
        check("merge_f2_framing", 64'(f2.framing), 64'(1));
        check("merge_gap", 64'(f2.start_cyc - f.end_cyc), 64'(2));
        repeat (600) @(negedge sys_clk);
        check("merge_no_third", 64'(fq.size()), 64'(0));
        check("merge_done_cnt", 64'(done_cnt - d0), 64'(2));

        // Counter changes mid-frame must not leak into the frame
        repeat (5) @(negedge sys_clk);
        fq.delete();
        pulse_cnt = 16'h5678;
        pulse_req(rc);
        repeat (150) @(negedge sys_clk);
        pulse_cnt = 16'h9999;
        wait_frames(1, 600);
        pop(f);
        check("capture_bytes",   64'(f.bytes),   64'(40'hA5_04_56_78_2A));
        check("capture_framing", 64'(f.framing), 64'(1));

        // Reset during byte 3 aborts the frame
        repeat (5) @(negedge sys_clk);
        fq.delete();
        d0 = done_cnt;
        pulse_req(rc);
        repeat (250) @(negedge sys_clk);
        check("pre_abort_busy", 64'(busy1), 64'(1));
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("abort_txd",  64'(txd1),  64'(1));
        check("abort_busy", 64'(busy1), 64'(0));
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (600) @(negedge sys_clk);
        check("abort_records", 64'(fq.size()), 64'(1));
        pop(f);
        check("abort_truncated", 64'(f.len < 50 * div), 64'(1));
        check("abort_no_done",   64'(done_cnt - d0), 64'(0));
        check("abort_idle_txd",  64'(txd1),  64'(1));
        check("abort_idle_busy", 64'(busy1), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/igbt_status_uart_tx.md
IGBT_STATUS_UART_TX -- requirements
Module: igbt_status_uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, UART bit rate.
REQ-003 SHALL have parameter AUTO_REPORT, default 1, which enables a frame on any change of igbt_status or scr_status when set to 1.
REQ-004 SHALL have port sys_clk, input, 1 bit: system clock; the block has one clock only.
REQ-005 SHALL have port sys_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port igbt_status, input, 5 bits: on-state flags for the 5 IGBTs.
REQ-007 SHALL have port scr_status, input, 2 bits: on-state flags for the 2 SCRs.
REQ-008 SHALL have port pulse_cnt, input, 16 bits: count of delivered stimulation pulses.
REQ-009 SHALL have port report_req, input, 1 bit: single-cycle request to send one status frame.
REQ-010 SHALL have port uart_txd, output, 1 bit: UART serial line, 8N1 format, idle high.
REQ-011 SHALL have port tx_busy, output, 1 bit: high while a frame is being sent.
REQ-012 SHALL have port frame_done, output, 1 bit: single-cycle pulse when a frame completes.

Function
REQ-013 SHALL set BAUD_DIV to CLK_FREQ/BAUD_RATE with integer truncation; with the defaults this is 434 cycles per bit.
REQ-014 SHALL send each frame as exactly 5 bytes in this order: 0xA5, STAT, CNT_H, CNT_L, CHK.
- STAT = {1'b0, scr_status[1:0], igbt_status[4:0]}.
- CNT_H = pulse_cnt[15:8].
- CNT_L = pulse_cnt[7:0].
- CHK = STAT ^ CNT_H ^ CNT_L.
REQ-015 SHALL send each byte as 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1); each bit lasts exactly BAUD_DIV cycles.
REQ-016 SHALL insert no idle gap between bytes, so a full frame lasts 50*BAUD_DIV cycles (21700 with the defaults).
REQ-017 SHALL capture igbt_status, scr_status and pulse_cnt into registers on the cycle the frame starts; input changes during the frame SHALL NOT alter the bytes sent.
REQ-018 SHALL use the states IDLE, START, DATA, STOP, and SHALL follow these transitions:
- IDLE->START when a trigger is present.
- START->DATA after BAUD_DIV cycles.
- DATA->STOP after 8 bits.
- STOP->START when bytes remain.
- STOP->IDLE after byte 5.
REQ-019 SHALL define a trigger as either:
- report_req=1; or
- with AUTO_REPORT=1, the registered previous value of {scr_status, igbt_status} differing from the current value.
REQ-020 SHALL, when a trigger is sampled in IDLE on cycle N, drive uart_txd=0 and tx_busy=1 from cycle N+1.
REQ-021 SHALL, for a trigger arriving while tx_busy=1, set a single pending flag; further triggers SHALL merge into that one flag.
REQ-022 SHALL, when the pending flag is set at the end of a frame, return to IDLE for exactly 1 cycle, then start a new frame with a fresh capture, and clear the flag.
REQ-023 SHALL treat simultaneous report_req and a status change as one trigger.
REQ-024 SHALL pulse frame_done for 1 cycle on the cycle after the last stop bit of byte 5 ends; tx_busy SHALL fall on that same cycle.
REQ-025 SHALL run the bit-period counter from 0 to BAUD_DIV-1 and wrap to 0, with no accumulated drift across the frame.

Reset
REQ-026 SHALL, while sys_rst_n=0 at a sys_clk edge, set:
- state to IDLE;
- uart_txd=1, tx_busy=0, frame_done=0;
- all counters, the pending flag and the captured registers to 0;
- the previous-status register to the current inputs, so that reset does not cause a spurious auto-report.
REQ-027 SHALL, on reset during a frame, abort the frame at once, hold uart_txd=1 from the next edge, and send no partial bytes afterwards.

Verification
REQ-028 SHALL cover this case: igbt_status=5'b00001, scr_status=2'b10, pulse_cnt=16'h1234, report_req for 1 cycle -> bytes A5, 41, 12, 34, 67 are sent; frame length is 21700 cycles; frame_done fires once.
REQ-029 SHALL cover this case: with AUTO_REPORT=1 and idle, igbt_status changes from 00000 to 00100 -> a frame starts 1 cycle later with STAT=0x04 and CHK=0x04^CNT_H^CNT_L.
REQ-030 SHALL cover this case: 3 report_req pulses during one frame -> exactly one more frame is sent, starting 2 cycles after the first frame_done, and carrying the values present at its own start.
REQ-031 SHALL cover this case: pulse_cnt changes during byte 2 of a frame -> CNT_H and CNT_L in that frame equal the value captured at frame start.
REQ-032 SHALL cover this case: sys_rst_n is driven low during byte 3 -> uart_txd=1 and tx_busy=0 one edge later; no frame starts after release unless a new trigger occurs.
REQ-033 SHALL cover this case: each bit is sampled at its mid-point (BAUD_DIV/2 = 217 cycles into the bit) -> all start bits read 0 and all stop bits read 1 across the frame.
